// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode and FSM state encodings for the two-requester logic-unit arbiter.
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Purely combinational bitwise datapath: AND / OR / XOR / NAND on WIDTH bits.
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] va,
  input  logic [WIDTH-1:0] vb,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] vy
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign vy[gi] = (op == OP_AND) ? (va[gi] & vb[gi]) :
                      (op == OP_OR)  ? (va[gi] | vb[gi]) :
                      (op == OP_XOR) ? (va[gi] ^ vb[gi]) :
                                       ~(va[gi] & vb[gi]);
    end
  endgenerate

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two requesters, with a
// registered execute stage, tagged response channel and per-requester counters.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_va,
  input  logic [WIDTH-1:0] req0_vb,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_va,
  input  logic [WIDTH-1:0] req1_vb,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_vy,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic [WIDTH-1:0] va_reg, vb_reg, rsp_vy_reg, vy_unit;
  logic [1:0]       op_reg;
  logic             id_reg;
  logic             grant;
  logic             accept;
  logic             rsp_done;
  logic [CNT_W-1:0] cnt_arr [2];

  // Grant is purely combinational; nothing is remembered in IDLE except who won last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // rst_n gating keeps both readies low while reset is asserted.
  assign req0_ready = rst_n && (state_reg == S_IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_reg == S_IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;
  assign rsp_done   = (state_reg == S_RESP) && rsp_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= 1'b1;
      va_reg         <= '0;
      vb_reg         <= '0;
      op_reg         <= OP_AND;
      id_reg         <= 1'b0;
      rsp_vy_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        va_reg         <= grant ? req1_va : req0_va;
        vb_reg         <= grant ? req1_vb : req0_vb;
        op_reg         <= grant ? req1_op : req0_op;
        id_reg         <= grant;
        last_grant_reg <= grant;
      end
      if (state_reg == S_EXEC) begin
        rsp_vy_reg <= vy_unit;
      end
    end
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .va (va_reg),
    .vb (vb_reg),
    .op (op_reg),
    .vy (vy_unit)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (rsp_done && (id_reg == 1'(gi))) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_arr[gi] = cnt_reg;
    end
  endgenerate

  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_id    = id_reg;
  assign rsp_vy    = rsp_vy_reg;
  assign busy      = (state_reg != S_IDLE);
  assign cnt0      = cnt_arr[0];
  assign cnt1      = cnt_arr[1];

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, single ops, opcodes, contention,
// backpressure and counter wrap, with hand-computed expected values.
module tb_logic_unit_arbiter;
  import logic_unit_arbiter_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk, rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_va, req0_vb, req1_va, req1_vb;
  logic [1:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0]  rsp_vy;
  logic [CW-1:0] cnt0, cnt1;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] cnt_model [2];

  logic_unit_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_va    (req0_va),
    .req0_vb    (req0_vb),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_va    (req1_va),
    .req1_vb    (req1_vb),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_vy     (rsp_vy),
    .busy       (busy),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int r, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] op);
    if (r == 0) begin
      req0_valid = v; req0_va = a; req0_vb = b; req0_op = op;
    end else begin
      req1_valid = v; req1_va = a; req1_vb = b; req1_op = op;
    end
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_cnt0"}, cnt0, cnt_model[0]);
    check_eq({tag, "_cnt1"}, cnt1, cnt_model[1]);
  endtask

  // One uncontended operation with rsp_ready high; checks the 2-cycle latency.
  task automatic run_single(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op, input logic [W-1:0] exp_vy);
    @(negedge clk);
    drive_req(r, 1'b1, a, b, op);
    rsp_ready = 1'b1;
    #1;
    check_eq("accept_ready", (r == 0) ? req0_ready : req1_ready, 1);
    @(negedge clk);
    drive_req(r, 1'b0, a, b, op);
    check_eq("exec_rsp_valid", rsp_valid, 0);
    check_eq("exec_busy", busy, 1);
    @(negedge clk);
    check_eq("resp_valid", rsp_valid, 1);
    check_eq("resp_id", rsp_id, r);
    check_eq("resp_vy", rsp_vy, exp_vy);
    cnt_model[r] = cnt_model[r] + 1'b1;
    @(negedge clk);
    check_eq("post_busy", busy, 0);
    check_counters("post");
    $display("txn req%0d va=%b vb=%b op=%b vy=%b cnt0=%0d cnt1=%0d", r, a, b, op, exp_vy, cnt0, cnt1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int resp_idx;
    logic [W-1:0] exp_vy;
    logic         exp_id;

    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive_req(0, 1'b1, 4'b0001, 4'b0001, OP_AND);
    drive_req(1, 1'b1, 4'b0001, 4'b0001, OP_AND);
    cnt_model[0] = '0;
    cnt_model[1] = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready0", req0_ready, 0);
    check_eq("rst_ready1", req1_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_vy", rsp_vy, 0);
    check_eq("rst_busy", busy, 0);
    check_counters("rst");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    $display("txn reset released");

    run_single(0, 4'b1010, 4'b1111, OP_AND, 4'b1010);
    run_single(1, 4'b1010, 4'b1111, OP_OR,   4'b1111);
    run_single(1, 4'b1010, 4'b1111, OP_XOR,  4'b0101);
    run_single(1, 4'b1010, 4'b1111, OP_NAND, 4'b0101);
    check_eq("opcodes_cnt1", cnt1, 3);

    // Reset while a response is stalled in RESP.
    @(negedge clk);
    drive_req(0, 1'b1, 4'b1100, 4'b0110, OP_XOR);
    rsp_ready = 1'b0;
    #1;
    check_eq("midrst_accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_in_resp", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_rsp_vy", rsp_vy, 0);
    cnt_model[0] = '0;
    cnt_model[1] = '0;
    check_counters("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset mid-RESP, in-flight op dropped");

    // Contention: both valid, grants must alternate starting with requester 0.
    @(negedge clk);
    drive_req(0, 1'b1, 4'b0011, 4'b0101, OP_XOR);
    drive_req(1, 1'b1, 4'b1100, 4'b1010, OP_AND);
    rsp_ready = 1'b1;
    resp_idx = 0;
    for (int c = 0; c < 40 && resp_idx < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        exp_id = 1'(resp_idx % 2);
        exp_vy = exp_id ? 4'b1000 : 4'b0110;
        check_eq("contend_id", rsp_id, exp_id);
        check_eq("contend_vy", rsp_vy, exp_vy);
        cnt_model[exp_id] = cnt_model[exp_id] + 1'b1;
        $display("txn contention rsp %0d id=%0d vy=%b", resp_idx, rsp_id, rsp_vy);
        resp_idx++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("contend_count", resp_idx, 4);
    @(negedge clk);
    check_counters("contend");

    // Backpressure: operands change mid-flight, rsp_ready low for 5 RESP cycles.
    @(negedge clk);
    drive_req(1, 1'b1, 4'b0110, 4'b0011, OP_OR);
    rsp_ready = 1'b0;
    #1;
    check_eq("bp_accept", req1_ready, 1);
    @(negedge clk);
    drive_req(1, 1'b1, 4'b1001, 4'b0001, OP_AND);
    check_eq("bp_exec_ready1", req1_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_rsp_valid", rsp_valid, 1);
      check_eq("bp_rsp_vy", rsp_vy, 4'b0111);
      check_eq("bp_ready1", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    cnt_model[1] = cnt_model[1] + 1'b1;
    @(negedge clk);
    check_eq("bp_next_ready1", req1_ready, 1);
    check_eq("bp_idle_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check_eq("bp2_exec_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check_eq("bp2_rsp_valid", rsp_valid, 1);
    check_eq("bp2_rsp_id", rsp_id, 1);
    check_eq("bp2_rsp_vy", rsp_vy, 4'b0001);
    req1_valid = 1'b0;
    cnt_model[1] = cnt_model[1] + 1'b1;
    @(negedge clk);
    check_counters("bp");
    $display("txn backpressure done cnt1=%0d", cnt1);

    // Counter wrap from a clean reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_model[0] = '0;
    cnt_model[1] = '0;
    for (int i = 0; i < 256; i++) begin
      run_single(0, 4'b1010, 4'b1111, OP_AND, 4'b1010);
      if (i == 254) check_eq("wrap_cnt0_255", cnt0, 255);
    end
    check_eq("wrap_cnt0_zero", cnt0, 0);
    check_eq("wrap_cnt1", cnt1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic datapath between two requesters.
- Each requester offers an operand pair and an opcode over a valid/ready handshake.
- The block grants requesters round-robin, computes the result in a registered execute stage, and returns it over a valid/ready response channel tagged with the requester ID.
- Sits between operand producers and the vector logic path; also keeps per-requester completion counters.

Parameters:
- WIDTH, 4, operand/result bit width.
- CNT_W, 8, width of each per-requester completion counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when high with valid.
- req0_va  in  WIDTH  requester 0 operand A.
- req0_vb  in  WIDTH  requester 0 operand B.
- req0_op  in  2  requester 0 opcode.
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 accept.
- req1_va  in  WIDTH  requester 1 operand A.
- req1_vb  in  WIDTH  requester 1 operand B.
- req1_op  in  2  requester 1 opcode.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that issued the result.
- rsp_vy  out  WIDTH  result.
- busy  out  1  high in any state other than IDLE.
- cnt0  out  CNT_W  completed responses for requester 0.
- cnt1  out  CNT_W  completed responses for requester 1.

Behaviour:
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 NAND. All operations are bitwise, WIDTH bits, with no carry.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. If only one valid is high, that requester is granted. If both are high, the requester that is not last_grant is granted.
  - reqN_ready = (state==IDLE) && grant==N. It may depend on valid, and is 0 outside IDLE.
  - On accept: latch va, vb, op and id into operand registers, set last_grant=id, go to EXEC.
- EXEC: one cycle. Compute the result into the rsp_vy register, go to RESP. Latency is accept edge +2 clocks to rsp_valid high.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_vy held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: increment cnt[rsp_id], wrapping modulo 2^CNT_W, and return to IDLE. A new request can therefore be accepted at the earliest one cycle after the handshake.
  - rsp_ready held low stalls indefinitely. Requester inputs are ignored in this state.
- Reset (async, any state, including mid-EXEC/RESP):
  - state=IDLE, last_grant=1 (so requester 0 wins the first contention).
  - rsp_valid=0, rsp_id=0, rsp_vy=0, busy=0, cnt0=cnt1=0, both ready=0 while rst_n low.
  - An in-flight operation is discarded with no response.
- A requester that drops valid before being accepted loses nothing; no grant is stored in IDLE.
- Operands are sampled only on the accept edge; later changes do not affect the in-flight result.

Decomposition:
- Shared package: opcode constants (OP_AND, OP_OR, OP_XOR, OP_NAND), state encoding constants (S_IDLE, S_EXEC, S_RESP).
- Sub-module: logic_unit, purely combinational, ports va, vb, op -> vy, parameterised by WIDTH. The arbiter instantiates it once.

Test Plan:
- Reset mid-RESP: accept an op, hold rsp_ready=0, pulse rst_n low -> rsp_valid=0 immediately, cnt0=cnt1=0, first later contention granted to requester 0.
- Single request: req0 va=1010 vb=1111 op=00 -> req0_ready high in the accept cycle, rsp_valid two clocks later with rsp_id=0, rsp_vy=1010, cnt0=1.
- All opcodes on req1 with va=1010 vb=1111: OR->1111, XOR->0101, NAND->0101; each rsp_id=1, cnt1 ends at 3.
- Contention: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1, and each response carries its own requester's operands.
- Backpressure: hold rsp_ready=0 for 5 cycles while req1 is valid -> rsp_vy stable, req1_ready=0 throughout; after the handshake, req1 is accepted on the next cycle.
- Counter wrap: complete 256 requester-0 operations with CNT_W=8 -> cnt0 returns to 0, cnt1 unchanged.
